data_mem_responder: RTL and testbench

Memory-side responder for the single-cycle MIPS datapath's load/store port. It accepts one word-sized read or write request at a time over a valid/ready handshake and returns a response after a fixed, parameterised latency. It flags misaligned or out-of-range addresses. It replaces the zero-latency `data_mem` when the machine is run against a multi-cycle memory model, and is the responder end of the core's data-memory interface.

---
 rtl/data_mem_pkg.sv | 13 +
 rtl/data_mem_array.sv | 21 ++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam int          DM_LAT_W = 4;
  localparam logic [31:0] DM_BASE  = 32'h1000_0000;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage: synchronous write, combinational read, no reset.
module data_mem_array #(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request, fixed-latency response,
// error flag for misaligned or out-of-range byte addresses.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          WORDS   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = DM_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error
);

  localparam int                  IDX_W    = $clog2(WORDS);
  localparam logic [32:0]         LIMIT    = {1'b0, BASE} + 33'(4 * WORDS);
  localparam logic [DM_LAT_W-1:0] CNT_INIT = (LATENCY > 1) ? DM_LAT_W'(LATENCY - 2) : '0;

  dm_state_t           state_q, state_d;
  logic [DM_LAT_W-1:0] cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                resp_error_q, resp_error_d;
  logic                req_ready_q, req_ready_d;

  logic                accept, commit, err, we;
  logic                cur_write;
  logic [31:0]         cur_addr, cur_wdata, rdata;
  logic [IDX_W-1:0]    idx;

  // With LATENCY=1 the commit happens on the accept edge, so the live inputs are used.
  assign cur_write = (state_q == IDLE) ? req_write : wr_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign accept = req_valid & req_ready_q;
  assign err    = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE) || ({1'b0, cur_addr} >= LIMIT);
  assign idx    = IDX_W'((cur_addr - BASE) >> 2);
  assign we     = commit & cur_write & ~err & reset;

  data_mem_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idx),
    .wdata (cur_wdata),
    .rdata (rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    commit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - DM_LAT_W'(1);
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_data_d  = '0;
          resp_error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == RESP) && (state_q != RESP)) begin
      commit       = 1'b1;
      resp_error_d = err;
      resp_data_d  = (cur_write || err) ? '0 : rdata;
    end

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 3, 1), vector table plus corner sequences.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_data  [3];
  logic        resp_error [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .WORDS   (1024),
      .LATENCY ((g == 0) ? 2 : ((g == 1) ? 3 : 1)),
      .BASE    (32'h1000_0000)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .resp_error (resp_error[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts and ends on a falling edge; returns with resp_valid seen (or timed out).
  task automatic send(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input bit ee, input int lat);
    int   n;
    exp_t e;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
    sb.push_back('{data: ed, err: ee});
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n = 1;
    @(negedge clk);
    while (!resp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency d%0d a=%h", d, a), 32'(n), 32'(lat));
    e = sb.pop_front();
    chk($sformatf("resp_data d%0d a=%h", d, a), resp_data[d], e.data);
    chk($sformatf("resp_error d%0d a=%h", d, a), {31'b0, resp_error[d]}, {31'b0, e.err});
  endtask

  task automatic finish_resp(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("post_hs_valid d%0d", d), {31'b0, resp_valid[d]}, 32'd0);
    chk($sformatf("post_hs_ready d%0d", d), {31'b0, req_ready[d]}, 32'd1);
    chk($sformatf("post_hs_data d%0d", d), resp_data[d], 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    logic [31:0] held_data;
    logic        held_err;

    vecs[0]  = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h1000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h1000_0000, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h1000_0FFC, 32'h5A5A_0001, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h1000_0002, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h1000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[6]  = '{1'b1, 32'h0FFF_FFFC, 32'h1111_1111, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h1000_1000, 32'h2222_2222, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h1000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b0, 32'h1000_0FFC, 32'h0,         32'h5A5A_0001, 1'b0};
    vecs[10] = '{1'b1, 32'h1000_0001, 32'h3333_3333, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h1000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};

    for (int d = 0; d < 3; d++) begin
      rst_n[d]      = 1'b0;
      req_valid[d]  = 1'b0;
      req_write[d]  = 1'b0;
      req_addr[d]   = '0;
      req_wdata[d]  = '0;
      resp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid d%0d", d), {31'b0, resp_valid[d]}, 32'd0);
      chk($sformatf("rst_data d%0d", d), resp_data[d], 32'd0);
      chk($sformatf("rst_error d%0d", d), {31'b0, resp_error[d]}, 32'd0);
      rst_n[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("rst_ready d%0d", d), {31'b0, req_ready[d]}, 32'd1);

    // Vector table on the LATENCY=2 instance
    for (int i = 0; i < 13; i++) begin
      send(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err, 2);
      finish_resp(0);
    end

    // Backpressure: response held while a new request is presented
    resp_ready[0] = 1'b0;
    send(0, 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    held_data = resp_data[0];
    held_err  = resp_error[0];
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h1000_0010;
    req_wdata[0] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid[0]}, 32'd1);
      chk("bp_data", resp_data[0], held_data);
      chk("bp_error", {31'b0, resp_error[0]}, {31'b0, held_err});
      chk("bp_ready", {31'b0, req_ready[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    finish_resp(0);
    send(0, 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    finish_resp(0);

    // Reset mid-BUSY on the LATENCY=3 instance
    send(1, 1'b1, 32'h1000_0020, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
    finish_resp(1);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h1000_0020;
    req_wdata[1] = 32'h1234_5678;
    chk("mid_busy_pre_ready", {31'b0, req_ready[1]}, 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n[1] = 1'b0;
    #1;
    chk("mid_busy_rst_valid", {31'b0, resp_valid[1]}, 32'd0);
    chk("mid_busy_rst_ready", {31'b0, req_ready[1]}, 32'd1);
    chk("mid_busy_rst_data", resp_data[1], 32'd0);
    chk("mid_busy_rst_error", {31'b0, resp_error[1]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_hold_valid", {31'b0, resp_valid[1]}, 32'd0);
    rst_n[1] = 1'b1;
    @(negedge clk);
    send(1, 1'b0, 32'h1000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    finish_resp(1);

    // LATENCY=1 throughput with req_valid held high
    send(2, 1'b1, 32'h1000_0040, 32'h0000_0077, 32'h0, 1'b0, 1);
    finish_resp(2);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b0;
    req_addr[2]  = 32'h1000_0040;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("thr_ready k%0d", k), {31'b0, req_ready[2]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("thr_valid k%0d", k), {31'b0, resp_valid[2]}, (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 1) chk($sformatf("thr_data k%0d", k), resp_data[2], 32'h0000_0077);
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
